alu_share_arb: RTL and testbench

- Shares the single combinational RV32I ALU between NUM_REQ requesters, e.g. the execute stage, the address-generation path and a debug port.
- Round-robin arbitration and one transaction in flight at a time.
- Operands and opcode are registered into the ALU; the result is registered back out with the requester ID on a valid/ready response channel.
- Sits between the requesting pipeline stages and the ALU instance.

---
 rtl/alu_share_arb_pkg.sv | 20 ++
 rtl/alu_share_arb_if.sv | 47 ++++
 rtl/alu_share_arb_rr_arbiter.sv | 35 +++
 rtl/alu_share_arb.sv | 134 +++++++++++++
 tb/tb_alu_share_arb.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU opcode encodings,
// control-code width and the arbiter FSM state type.
package alu_pkg;

  localparam int ALU_OP_W = 6;

  localparam logic [ALU_OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [ALU_OP_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [ALU_OP_W-1:0] OP_ADDI = 6'b001010;
  localparam logic [ALU_OP_W-1:0] OP_SLLI = 6'b001011;
  localparam logic [ALU_OP_W-1:0] OP_LUI  = 6'b010010;
  localparam logic [ALU_OP_W-1:0] OP_BEQ  = 6'b011010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// Bundle of requester, ALU-side and response signals around the shared ALU.
// slave: the arbiter. master: requesters, ALU and response consumer.
interface alu_share_arb_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int ID_W    = 3
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ*DATA_W-1:0] req_src1;
  logic [NUM_REQ*DATA_W-1:0] req_src2;
  logic [NUM_REQ*DATA_W-1:0] req_imm;
  logic [NUM_REQ*4-1:0]      req_shamt;

  logic [OP_W-1:0]           alu_cntrl;
  logic [DATA_W-1:0]         alu_src1;
  logic [DATA_W-1:0]         alu_src2;
  logic [DATA_W-1:0]         alu_imm;
  logic [3:0]                alu_shamt;
  logic [DATA_W-1:0]         alu_result;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      busy;

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, req_imm, req_shamt,
    output req_ready,
    output alu_cntrl, alu_src1, alu_src2, alu_imm, alu_shamt,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_result, busy,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_src1, req_src2, req_imm, req_shamt,
    input  req_ready,
    input  alu_cntrl, alu_src1, alu_src2, alu_imm, alu_shamt,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_result, busy,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: scans requests starting one past the
// last granted index, wrapping modulo N. Grant is one-hot or zero.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // First asserted request after last_i wins; nothing is granted when disabled.
  always_comb begin
    int unsigned k;
    k     = '0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    if (en_i) begin
      for (int unsigned off = 1; off <= N; off++) begin
        k = 32'(last_i) + off;
        if (k >= N) k = k - N;
        if (!vld_o && req_i[k]) begin
          vld_o    = 1'b1;
          gnt_o[k] = 1'b1;
          idx_o    = IW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant,
// registered operands to the ALU, registered result with requester ID out.
// Optional macro ALU_ARB_BYPASS_EN: arbitrate again in RESP when the response
// is consumed, allowing RESP->EXEC back-to-back (1 op per 2 cycles).
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = ALU_OP_W,
  parameter int ID_W    = 3
) (
  input  logic          clk,
  input  logic          rst,
  alu_share_arb_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      rr_last_q;
  logic [IW-1:0]      cur_id_q;
  logic [OP_W-1:0]    alu_cntrl_q;
  logic [DATA_W-1:0]  alu_src1_q, alu_src2_q, alu_imm_q;
  logic [3:0]         alu_shamt_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [DATA_W-1:0]  rsp_result_q;

  logic               arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic               load_op;
  logic               cap_rsp;
  logic               clr_rsp;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i  (bus.req_valid),
    .last_i (rr_last_q),
    .en_i   (arb_en),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .vld_o  (gnt_vld)
  );

  // Next-state and per-state control strobes.
  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    load_op = 1'b0;
    cap_rsp = 1'b0;
    clr_rsp = 1'b0;
    unique case (state_q)
      IDLE: begin
        arb_en = 1'b1;
        if (gnt_vld) begin
          load_op = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cap_rsp = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          clr_rsp = 1'b1;
          state_d = IDLE;
`ifdef ALU_ARB_BYPASS_EN
          // Response leaves this cycle, so the ALU registers are free to reload.
          arb_en = 1'b1;
          if (gnt_vld) begin
            load_op = 1'b1;
            state_d = EXEC;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture into the ALU registers, round-robin pointer and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q    <= IW'(NUM_REQ - 1);
      cur_id_q     <= '0;
      alu_cntrl_q  <= '0;
      alu_src1_q   <= '0;
      alu_src2_q   <= '0;
      alu_imm_q    <= '0;
      alu_shamt_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      if (load_op) begin
        alu_cntrl_q <= bus.req_op[int'(gnt_idx)*OP_W +: OP_W];
        alu_src1_q  <= bus.req_src1[int'(gnt_idx)*DATA_W +: DATA_W];
        alu_src2_q  <= bus.req_src2[int'(gnt_idx)*DATA_W +: DATA_W];
        alu_imm_q   <= bus.req_imm[int'(gnt_idx)*DATA_W +: DATA_W];
        alu_shamt_q <= bus.req_shamt[int'(gnt_idx)*4 +: 4];
        rr_last_q   <= gnt_idx;
        cur_id_q    <= gnt_idx;
      end
      if (cap_rsp) begin
        rsp_result_q <= bus.alu_result;
        rsp_id_q     <= ID_W'(cur_id_q);
        rsp_valid_q  <= 1'b1;
      end else if (clr_rsp) begin
        rsp_valid_q  <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.alu_cntrl  = alu_cntrl_q;
  assign bus.alu_src1   = alu_src1_q;
  assign bus.alu_src2   = alu_src2_q;
  assign bus.alu_imm    = alu_imm_q;
  assign bus.alu_shamt  = alu_shamt_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: a small ALU model sits on the alu_* side,
// expected {id,result} pairs are queued as stimulus is driven and popped when
// a response handshake occurs.
module tb_alu_share_arb;
  import alu_pkg::*;

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t sb[$];
  int   glog[$];
  int   rsp_cyc_q[$];

  alu_share_arb_if #(.NUM_REQ(2), .DATA_W(32), .OP_W(6), .ID_W(3)) bus ();

  alu_share_arb #(.NUM_REQ(2), .DATA_W(32), .OP_W(6), .ID_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU on the shared side of the arbiter.
  always_comb begin
    case (bus.alu_cntrl)
      OP_ADD:  bus.alu_result = bus.alu_src1 + bus.alu_src2;
      OP_SUB:  bus.alu_result = bus.alu_src1 - bus.alu_src2;
      OP_ADDI: bus.alu_result = bus.alu_src1 + bus.alu_imm;
      OP_SLLI: bus.alu_result = bus.alu_src1 << bus.alu_shamt;
      OP_LUI:  bus.alu_result = bus.alu_imm << 12;
      OP_BEQ:  bus.alu_result = {31'd0, bus.alu_src1 == bus.alu_src2};
      default: bus.alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Response monitor: every completed response handshake pops the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        chk("rsp_result", 64'(bus.rsp_result), 64'(e.res));
      end
      rsp_cyc_q.push_back(cyc);
    end
  end

  task automatic set_req(input int i, input logic [5:0] op, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] imm, input logic [3:0] sh);
    bus.req_op[i*6 +: 6]     = op;
    bus.req_src1[i*32 +: 32] = s1;
    bus.req_src2[i*32 +: 32] = s2;
    bus.req_imm[i*32 +: 32]  = imm;
    bus.req_shamt[i*4 +: 4]  = sh;
  endtask

  task automatic push_exp(input int id, input logic [31:0] res);
    exp_t e;
    e.id  = 3'(id);
    e.res = res;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Run until the scoreboard drains and all requests are withdrawn; requester i
  // drops valid once it has been granted lim_i times.
  task automatic run(input int lim0, input int lim1, input int budget);
    int g0, g1;
    bit done;
    g0 = 0; g1 = 0; done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      chk("ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
      if (bus.req_valid[0] && bus.req_ready[0]) begin g0++; glog.push_back(0); end
      if (bus.req_valid[1] && bus.req_ready[1]) begin g1++; glog.push_back(1); end
      if (sb.size() == 0 && bus.req_valid == '0) begin
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (g0 >= lim0) bus.req_valid[0] = 1'b0;
        if (g1 >= lim1) bus.req_valid[1] = 1'b0;
      end
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d n_err=%0d", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    int exp_gap;
`ifdef ALU_ARB_BYPASS_EN
    exp_gap = 2;
`else
    exp_gap = 3;
`endif
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
    bus.req_imm   = '0;
    bus.req_shamt = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_alu_cntrl", 64'(bus.alu_cntrl), 64'd0);
    chk("rst_alu_src1", 64'(bus.alu_src1), 64'd0);
    chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single op: ADD 5+7, accept at T, response at T+2
    set_req(0, OP_ADD, 32'd5, 32'd7, 32'd0, 4'd0);
    bus.req_valid[0] = 1'b1;
    push_exp(0, 32'd12);
    @(negedge clk);
    chk("single_ready", 64'(bus.req_ready), 64'b01);
    chk("single_busy_T", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    chk("single_busy_T1", 64'(bus.busy), 64'd1);
    chk("single_valid_T1", 64'(bus.rsp_valid), 64'd0);
    chk("single_src1", 64'(bus.alu_src1), 64'd5);
    @(negedge clk);
    chk("single_busy_T2", 64'(bus.busy), 64'd1);
    chk("single_valid_T2", 64'(bus.rsp_valid), 64'd1);
    @(negedge clk);
    chk("single_idle", 64'(bus.busy), 64'd0);
    chk("single_drained", 64'(sb.size()), 64'd0);

    // Round robin with both requesters continuously valid
    do_reset();
    glog.delete();
    rsp_cyc_q.delete();
    set_req(0, OP_ADDI, 32'd1, 32'd0, 32'd2, 4'd0);
    set_req(1, OP_ADDI, 32'd10, 32'd0, 32'd20, 4'd0);
    push_exp(0, 32'd3); push_exp(1, 32'd30);
    push_exp(0, 32'd3); push_exp(1, 32'd30);
    bus.req_valid = 2'b11;
    run(2, 2, 60);
    chk("rr_grant_count", 64'(glog.size()), 64'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk($sformatf("rr_grant%0d", i), 64'(glog[i]), 64'(i % 2));
    chk("rr_rsp_count", 64'(rsp_cyc_q.size()), 64'd4);
    for (int i = 1; i < 4 && i < rsp_cyc_q.size(); i++)
      chk($sformatf("rr_rsp_gap%0d", i), 64'(rsp_cyc_q[i] - rsp_cyc_q[i-1]), 64'(exp_gap));

    // Backpressure: LUI held in RESP for 5 cycles with a competing request
    @(posedge clk); #1;
    set_req(0, OP_LUI, 32'd0, 32'd0, 32'd1, 4'd0);
    bus.req_valid[0] = 1'b1;
    push_exp(0, 32'h0000_1000);
    @(negedge clk);
    chk("bp_ready", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    bus.rsp_ready    = 1'b0;
    set_req(1, OP_ADD, 32'd1, 32'd1, 32'd0, 4'd0);
    bus.req_valid[1] = 1'b1;
    @(negedge clk);
    chk("bp_exec_ready", 64'(bus.req_ready), 64'd0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_result", 64'(bus.rsp_result), 64'h1000);
      chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    push_exp(1, 32'd2);
    run(0, 1, 30);

    // Reset while EXEC: in-flight op discarded, requester 0 regains priority
    @(posedge clk); #1;
    set_req(1, OP_ADD, 32'd2, 32'd3, 32'd0, 4'd0);
    bus.req_valid[1] = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 64'(bus.req_ready), 64'b10);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_mid_busy0", 64'(bus.busy), 64'd0);
    chk("rst_mid_cntrl", 64'(bus.alu_cntrl), 64'd0);
    chk("rst_mid_src1", 64'(bus.alu_src1), 64'd0);
    chk("rst_mid_src2", 64'(bus.alu_src2), 64'd0);
    chk("rst_mid_imm", 64'(bus.alu_imm), 64'd0);
    chk("rst_mid_shamt", 64'(bus.alu_shamt), 64'd0);
    @(posedge clk); #1;
    glog.delete();
    set_req(0, OP_ADD, 32'd1, 32'd2, 32'd0, 4'd0);
    set_req(1, OP_ADD, 32'd4, 32'd4, 32'd0, 4'd0);
    push_exp(0, 32'd3); push_exp(1, 32'd8);
    bus.req_valid = 2'b11;
    run(1, 1, 40);
    chk("rst_prio_count", 64'(glog.size()), 64'd2);
    if (glog.size() > 0) chk("rst_prio_first", 64'(glog[0]), 64'd0);

    // Unsupported opcode passes through and yields 0; SLLI 3<<4
    @(posedge clk); #1;
    set_req(0, 6'b111111, 32'd5, 32'd5, 32'd5, 4'd1);
    push_exp(0, 32'd0);
    bus.req_valid[0] = 1'b1;
    run(1, 0, 20);
    chk("dflt_cntrl", 64'(bus.alu_cntrl), 64'h3f);
    @(posedge clk); #1;
    set_req(0, OP_SLLI, 32'd3, 32'd0, 32'd3, 4'd4);
    push_exp(0, 32'd48);
    bus.req_valid[0] = 1'b1;
    run(1, 0, 20);
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
